cntry_car_sensor: RTL

- Vehicle-detect front end for the country-road approach of the traffic-light controller.
- Debounces the raw inductive-loop input and counts vehicles queued at the country light.
- Drives the controller's car-waiting input `x`, and consumes the controller's `cntry` light code to retire queued vehicles while the country light is GREEN.
- Sits between the loop-detector pad and the signal controller.

---
 rtl/cntry_car_sensor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cntry_car_sensor.sv
// Country-road vehicle detector: synchronises and debounces the loop input, queues cars.
// Optional stuck-sensor fail-safe is enabled with `define CNTRY_SENSOR_STUCK_EN.
module cntry_car_sensor #(
    parameter int DEBOUNCE      = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int CNT_W         = 4,
    parameter int STUCK_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             raw_sense,
    input  logic [1:0]       cntry,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic             stuck
);

    localparam logic [1:0] EMPTY     = 2'd0;
    localparam logic [1:0] ARMING    = 2'd1;
    localparam logic [1:0] OCCUPIED  = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    localparam logic [1:0] GREEN = 2'd2;

    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam int DW = $clog2(DEPART_CYCLES + 1);

    localparam logic [SW-1:0]    DEB_V    = SW'(DEBOUNCE);
    localparam logic [SW-1:0]    ONE_V    = SW'(1);
    localparam logic [DW-1:0]    DEP_LAST = DW'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SW-1:0]    stable_cnt;
    logic [SW-1:0]    stable_nxt;
    logic [DW-1:0]    dep_cnt;
    logic [DW-1:0]    dep_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             stuck_nxt;
    logic             arrive;
    logic             depart;
    logic             green;
    logic             queued;

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        arrive     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (s2) begin
                    state_nxt  = ARMING;
                    stable_nxt = ONE_V;
                end
            end
            ARMING: begin
                if (stable_cnt == DEB_V) begin
                    state_nxt = OCCUPIED;
                    arrive    = 1'b1;
                end else if (!s2) begin
                    state_nxt = EMPTY;
                end else begin
                    stable_nxt = stable_cnt + 1'b1;
                end
            end
            OCCUPIED: begin
                if (!s2) begin
                    state_nxt  = RELEASING;
                    stable_nxt = ONE_V;
                end
            end
            RELEASING: begin
                if (stable_cnt == DEB_V) begin
                    state_nxt = EMPTY;
                end else if (s2) begin
                    state_nxt = OCCUPIED;
                end else begin
                    stable_nxt = stable_cnt + 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Partial GREEN progress is dropped whenever the light leaves GREEN.
    assign green  = (cntry == GREEN);
    assign queued = (car_count != '0);
    assign depart = green && queued && (dep_cnt == DEP_LAST);

    always_comb begin
        dep_nxt = '0;
        if (green && queued && !depart) begin
            dep_nxt = dep_cnt + 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = car_count;
        ovf_nxt = overflow;
        unique case (1'b1)
            (arrive && !depart): begin
                if (car_count == CNT_MAX) begin
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = car_count + 1'b1;
                end
            end
            (depart && !arrive): cnt_nxt = car_count - 1'b1;
            default: ;
        endcase
    end

`ifdef CNTRY_SENSOR_STUCK_EN
    localparam int OW = $clog2(STUCK_CYCLES + 1);
    localparam logic [OW-1:0] STK_V = OW'(STUCK_CYCLES);

    logic [OW-1:0] occ_cnt;
    logic [OW-1:0] occ_nxt;

    always_comb begin
        occ_nxt = '0;
        if (state == OCCUPIED || state == RELEASING) begin
            occ_nxt = (occ_cnt == STK_V) ? occ_cnt : occ_cnt + 1'b1;
        end
    end

    assign stuck_nxt = stuck | (occ_nxt == STK_V);

    always_ff @(posedge clk) begin
        if (!clear) begin
            occ_cnt <= '0;
        end else begin
            occ_cnt <= occ_nxt;
        end
    end
`else
    localparam int STUCK_UNUSED = STUCK_CYCLES;

    assign stuck_nxt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clear) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            state      <= EMPTY;
            stable_cnt <= '0;
            dep_cnt    <= '0;
            car_count  <= '0;
            overflow   <= 1'b0;
            stuck      <= 1'b0;
            x          <= 1'b0;
        end else begin
            s1         <= raw_sense;
            s2         <= s1;
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            dep_cnt    <= dep_nxt;
            car_count  <= cnt_nxt;
            overflow   <= ovf_nxt;
            stuck      <= stuck_nxt;
            x          <= (cnt_nxt != '0) | stuck_nxt;
        end
    end

endmodule
